// File: rtl/w0rm_core_mem_arbiter_pkg.sv
// Shared core package: arbiter state encoding and default bus widths used
// by the core stages that sit around the memory arbiter.
package w0rm_core_mem_arbiter_pkg;

    // Default address/data widths of the core memory-side interfaces.
    localparam int CORE_ADDR_WIDTH = 32;
    localparam int CORE_DATA_WIDTH = 32;

    // Width of the fetch-starvation counter; wide enough for limits up to 15.
    localparam int STARVE_CNT_W = 4;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/w0rm_core_mem_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// at_limit tells the arbiter to hand the next grant to fetch.
module w0rm_core_starve_counter
    import w0rm_core_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/w0rm_core_mem_arbiter.sv
// Memory-port arbiter between instruction fetch (read-only) and load/store.
// One transaction in flight; data has priority unless fetch has been passed
// over STARVE_LIMIT times in a row. A branch flush drops the fetch response.
module w0rm_core_mem_arbiter
    import w0rm_core_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = CORE_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CORE_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    // fetch requester
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    input  logic                    if_flush,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_data,
    // load/store requester
    input  logic                    d_req_valid,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_write,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_req_ready,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    // memory port
    output logic                    mem_valid,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_e state_q, state_d;
    logic       drop_q, drop_d;     // in-flight fetch response is to be discarded
    logic       wr_q, wr_d;         // in-flight data transaction is a store
    logic       rst_q, rst_d;       // reset was asserted last cycle
    logic       out_en;
    logic       d_win, i_win;
    logic       starve_inc, starve_clr, starve_at_limit;

    // Outputs stay quiet during reset and for one cycle after it.
    assign out_en = ~reset & ~rst_q;

    w0rm_core_starve_counter #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (starve_at_limit)
    );

    // Arbitration, memory mux, response routing and next-state logic.
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        wr_d          = wr_q;
        rst_d         = reset;
        d_win         = 1'b0;
        i_win         = 1'b0;
        starve_inc    = 1'b0;
        starve_clr    = 1'b0;
        if_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        if_resp_data  = '0;
        d_req_ready   = 1'b0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        mem_valid     = 1'b0;
        mem_addr      = '0;
        mem_write     = 1'b0;
        mem_wdata     = '0;
        mem_wstrb     = '0;

        if (out_en) begin
            case (state_q)
                ST_IDLE: begin
                    d_win = d_req_valid && !(if_req_valid && starve_at_limit);
                    i_win = !d_win && if_req_valid;
                    if (!if_req_valid) begin
                        starve_clr = 1'b1;
                    end
                    if (d_win) begin
                        mem_valid = 1'b1;
                        mem_addr  = d_req_addr;
                        mem_write = d_req_write;
                        mem_wdata = d_req_wdata;
                        mem_wstrb = d_req_wstrb;
                        if (mem_ready) begin
                            d_req_ready = 1'b1;
                            wr_d        = d_req_write;
                            starve_inc  = if_req_valid;
                            state_d     = ST_D_BUSY;
                        end
                    end else if (i_win) begin
                        mem_valid = 1'b1;
                        mem_addr  = if_req_addr;
                        if (mem_ready) begin
                            if_req_ready = 1'b1;
                            starve_clr   = 1'b1;
                            drop_d       = if_flush;
                            state_d      = ST_IF_BUSY;
                        end
                    end
                end
                ST_IF_BUSY: begin
                    if (if_flush) begin
                        drop_d = 1'b1;
                    end
                    if (mem_resp_valid) begin
                        if_resp_valid = !drop_q && !if_flush;
                        if_resp_data  = if_resp_valid ? mem_rdata : '0;
                        drop_d        = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_resp_valid) begin
                        d_resp_valid = 1'b1;
                        d_resp_data  = wr_q ? '0 : mem_rdata;
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // State and transaction-attribute registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            wr_q    <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rst_q   <= rst_d;
        end
    end

endmodule

// File: tb/tb_w0rm_core_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch, priority, starvation, flush,
// store with back-pressure and reset mid-transaction.
module tb_w0rm_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_write;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    w0rm_core_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_flush       (if_flush),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_addr     (d_req_addr),
        .d_req_write    (d_req_write),
        .d_req_wdata    (d_req_wdata),
        .d_req_wstrb    (d_req_wstrb),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait to the sampling point in the middle of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    int exp_seq [10];
    int grant;

    initial begin
        exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        reset          = 1'b1;
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h2000_0000;
        if_flush       = 1'b0;
        d_req_valid    = 1'b1;
        d_req_addr     = 32'h1000_0000;
        d_req_write    = 1'b0;
        d_req_wdata    = '0;
        d_req_wstrb    = '0;
        mem_ready      = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        // ---- reset: outputs quiet during reset and the cycle after ----
        next_cycle();
        sample();
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_d_ready", 32'(d_req_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check_eq("post_rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("post_rst_if_ready", 32'(if_req_ready), 32'd0);
        next_cycle();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        next_cycle();

        // ---- fetch only ----
        if_req_valid = 1'b1;
        if_req_addr  = 32'h2000_0000;
        sample();
        check_eq("f_mem_valid", 32'(mem_valid), 32'd1);
        check_eq("f_mem_addr", mem_addr, 32'h2000_0000);
        check_eq("f_mem_write", 32'(mem_write), 32'd0);
        check_eq("f_if_ready", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid = 1'b0;
        sample();
        check_eq("f_busy_if_ready", 32'(if_req_ready), 32'd0);
        check_eq("f_busy_mem_valid", 32'(mem_valid), 32'd0);
        next_cycle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        sample();
        check_eq("f_resp_valid", 32'(if_resp_valid), 32'd1);
        check_eq("f_resp_data", if_resp_data, 32'h1234_5678);
        check_eq("f_d_resp_valid", 32'(d_resp_valid), 32'd0);
        next_cycle();
        mem_resp_valid = 1'b0;
        sample();
        check_eq("f_resp_pulse", 32'(if_resp_valid), 32'd0);
        next_cycle();

        // ---- simultaneous: data first, fetch right after ----
        if_req_valid = 1'b1;
        if_req_addr  = 32'h2000_0004;
        d_req_valid  = 1'b1;
        d_req_addr   = 32'h1000_0000;
        d_req_write  = 1'b0;
        sample();
        check_eq("s_d_ready", 32'(d_req_ready), 32'd1);
        check_eq("s_if_ready", 32'(if_req_ready), 32'd0);
        check_eq("s_mem_addr", mem_addr, 32'h1000_0000);
        next_cycle();
        d_req_valid    = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        sample();
        check_eq("s_d_resp_valid", 32'(d_resp_valid), 32'd1);
        check_eq("s_d_resp_data", d_resp_data, 32'hCAFE_0001);
        check_eq("s_if_resp_valid", 32'(if_resp_valid), 32'd0);
        next_cycle();
        mem_resp_valid = 1'b0;
        sample();
        check_eq("s_if_ready_after", 32'(if_req_ready), 32'd1);
        check_eq("s_mem_addr_after", mem_addr, 32'h2000_0004);
        next_cycle();
        if_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1111_0000;
        sample();
        check_eq("s_if_resp_valid2", 32'(if_resp_valid), 32'd1);
        next_cycle();
        mem_resp_valid = 1'b0;
        next_cycle();

        // ---- starvation: both requesters always valid, 1=D 2=I ----
        if_req_valid   = 1'b1;
        d_req_valid    = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_00AA;
        for (int i = 0; i < 10; i++) begin
            sample();
            grant = d_req_ready ? 1 : (if_req_ready ? 2 : 0);
            check_eq($sformatf("starve_grant%0d", i), 32'(grant), 32'(exp_seq[i]));
            next_cycle();
            next_cycle();
        end
        if_req_valid   = 1'b0;
        d_req_valid    = 1'b0;
        mem_resp_valid = 1'b0;
        next_cycle();

        // ---- flush during IF_BUSY ----
        if_req_valid = 1'b1;
        if_req_addr  = 32'h2000_0100;
        sample();
        check_eq("fl_if_ready", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid = 1'b0;
        if_flush     = 1'b1;
        next_cycle();
        if_flush       = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEAD_BEEF;
        sample();
        check_eq("fl_resp_dropped", 32'(if_resp_valid), 32'd0);
        check_eq("fl_resp_data", if_resp_data, 32'd0);
        next_cycle();
        mem_resp_valid = 1'b0;
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h2000_0104;
        sample();
        check_eq("fl_next_if_ready", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0BAD_F00D;
        sample();
        check_eq("fl_next_resp_valid", 32'(if_resp_valid), 32'd1);
        check_eq("fl_next_resp_data", if_resp_data, 32'h0BAD_F00D);
        next_cycle();
        mem_resp_valid = 1'b0;
        next_cycle();

        // ---- store with mem_ready low for 3 cycles ----
        d_req_valid = 1'b1;
        d_req_write = 1'b1;
        d_req_addr  = 32'h1000_0010;
        d_req_wdata = 32'hA5A5_A5A5;
        d_req_wstrb = 4'b0011;
        mem_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq($sformatf("st_wait%0d_ready", i), 32'(d_req_ready), 32'd0);
            check_eq($sformatf("st_wait%0d_mem", i),
                     {mem_valid, mem_write, 26'd0, mem_wstrb}, {1'b1, 1'b1, 26'd0, 4'b0011});
            check_eq($sformatf("st_wait%0d_addr", i), mem_addr, 32'h1000_0010);
            check_eq($sformatf("st_wait%0d_wdata", i), mem_wdata, 32'hA5A5_A5A5);
            next_cycle();
        end
        mem_ready = 1'b1;
        sample();
        check_eq("st_accept_ready", 32'(d_req_ready), 32'd1);
        next_cycle();
        d_req_valid    = 1'b0;
        d_req_write    = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        sample();
        check_eq("st_ack_valid", 32'(d_resp_valid), 32'd1);
        check_eq("st_ack_data", d_resp_data, 32'd0);
        next_cycle();
        mem_resp_valid = 1'b0;
        next_cycle();

        // ---- reset asserted in D_BUSY, late memory response ----
        d_req_valid = 1'b1;
        d_req_addr  = 32'h1000_0020;
        sample();
        check_eq("rb_d_ready", 32'(d_req_ready), 32'd1);
        next_cycle();
        d_req_valid = 1'b0;
        reset       = 1'b1;
        sample();
        check_eq("rb_in_reset_resp", 32'(d_resp_valid), 32'd0);
        next_cycle();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5555_AAAA;
        sample();
        check_eq("rb_after_d_resp", 32'(d_resp_valid), 32'd0);
        check_eq("rb_after_mem_valid", 32'(mem_valid), 32'd0);
        next_cycle();
        sample();
        check_eq("rb_late_d_resp", 32'(d_resp_valid), 32'd0);
        check_eq("rb_late_d_data", d_resp_data, 32'd0);
        next_cycle();
        mem_resp_valid = 1'b0;
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h2000_0200;
        sample();
        check_eq("rb_idle_if_ready", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w0rm_core_mem_arbiter.md
Name: w0rm_core_mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester (read-only) and the load/store requester (read/write).
- Single outstanding transaction. Data requests take priority; a starvation counter guarantees forward progress for fetch.
- Handles branch flushes by discarding an in-flight fetch response.
- Sits between IFetch/MemUnit and the bus/BRAM interface.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; must be a multiple of 8.
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_WIDTH  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  branch flush: discard the pending fetch response
- if_resp_valid  out  1  fetch data valid, one-cycle pulse
- if_resp_data  out  DATA_WIDTH  fetch read data
- d_req_valid  in  1  data request
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_write  in  1  1 = store, 0 = load
- d_req_wdata  in  DATA_WIDTH  store data
- d_req_wstrb  in  DATA_WIDTH/8  store byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  load data or store acknowledge, one-cycle pulse
- d_resp_data  out  DATA_WIDTH  load data (0 for stores)
- mem_valid  out  1  request to memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_write  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables
- mem_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response; required for both reads and writes
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- FSM states: IDLE, IF_BUSY, D_BUSY. Reset sets state IDLE, starve_cnt 0, drop_r 0.
- All outputs are 0 during reset and in the cycle after reset.
- IDLE arbitration is combinational:
  - winner = data if d_req_valid, unless (if_req_valid and starve_cnt == STARVE_LIMIT); otherwise fetch if if_req_valid.
  - mem_* are muxed from the winner. mem_valid = winner exists.
  - Fetch transactions drive mem_write = 0 and mem_wstrb = 0.
- Acceptance:
  - When mem_valid && mem_ready: the winner's *_req_ready is high that same cycle.
  - Next state is IF_BUSY or D_BUSY.
  - The loser's ready is 0. If mem_ready = 0, nothing is accepted and requesters hold.
- Starvation counter:
  - starve_cnt increments on each accepted data grant while if_req_valid = 1.
  - It clears on a fetch grant, or whenever if_req_valid = 0 in IDLE.
  - It saturates at STARVE_LIMIT.
- BUSY states:
  - mem_valid = 0 and both readys = 0.
  - On mem_resp_valid: route the response to the owner (resp_valid = 1 and resp_data = mem_rdata in the same cycle, combinational path), then go to IDLE.
  - Minimum spacing is 2 cycles per transaction.
- Flush:
  - drop_r sets when if_flush is high in IF_BUSY, or in IDLE in the same cycle as a fetch acceptance.
  - While drop_r or if_flush is high, if_resp_valid is suppressed at response time.
  - drop_r clears on returning to IDLE.
  - if_flush in D_BUSY, or in IDLE with no fetch grant, has no effect.
- Responses arriving in IDLE are ignored: no resp_valid.
- d_resp_data = 0 for store acknowledges. Unused resp_data outputs are don't-care but held at 0 when their valid is low.
- Reset mid-transaction forces IDLE immediately; any later memory response is discarded.
- Requesters must hold addr/data stable while valid and not ready. The arbiter does not register request payloads.

Decomposition:
- Shared core package: state encodings (IDLE = 2'd0, IF_BUSY = 2'd1, D_BUSY = 2'd2) and the default ADDR_WIDTH/DATA_WIDTH constants used by the other core stages.
- Optional sub-module w0rm_core_starve_counter: a saturating counter with inc, clr and at_limit. Otherwise keep the block flat.

Test Plan:
- Fetch only: if_req addr 0x2000_0000, mem_ready = 1, response 0x1234_5678 two cycles later -> if_req_ready pulses once; if_resp_valid = 1 with 0x1234_5678; d_resp_valid stays 0.
- Simultaneous requests: if_req 0x2000_0004 and d_req load 0x1000_0000 -> data granted first; fetch is granted in the IDLE cycle after the data response.
- Starvation: STARVE_LIMIT = 4, fetch and data held valid continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Flush: fetch accepted, if_flush pulsed in IF_BUSY, memory responds 0xDEAD_BEEF -> if_resp_valid stays 0; FSM returns to IDLE; the next fetch completes normally.
- Store: d_req_write = 1, addr 0x1000_0010, wdata 0xA5A5_A5A5, wstrb 4'b0011, mem_ready low for 3 cycles -> d_req_ready only on the accept cycle; mem_* stable throughout; ack gives d_resp_valid = 1 with d_resp_data = 0.
- Reset asserted in D_BUSY, memory response arriving one cycle after reset deasserts -> no resp_valid; all outputs 0; state IDLE.
